bcd_serial_add_ctrl: RTL
========================

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 Parameter: DIGITS, default 4, number of BCD digits per operand (legal range 1-16).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 b  input  4*DIGITS  operand B, packed BCD, same packing as a.
REQ-007 cin  input  1  carry into digit 0.
REQ-008 busy  output  1  high while digits are being processed.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 sum  output  4*DIGITS  packed BCD result, registered.
REQ-011 cout  output  1  decimal carry out of the most significant digit, registered.
REQ-012 err  output  1  high if any operand digit of the completed operation exceeded 9, registered.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at a rising edge SHALL latch a, b and cin into internal registers, clear the digit counter and the running error flag, and enter RUN.
REQ-015 IDLE: start=0 SHALL leave the FSM in IDLE with sum, cout and err unchanged.
REQ-016 RUN: each rising edge SHALL process exactly one digit, LSB first, using one shared single-digit BCD add step; digit i is processed on the (i+1)th edge after acceptance.
REQ-017 Digit step: s = a_i + b_i + carry, 5-bit unsigned; if s > 9, digit = (s + 6) mod 16 and carry = 1; otherwise digit = s and carry = 0.
REQ-018 Carry into digit 0 SHALL be the latched cin; the carry out of each digit SHALL feed the next digit.
REQ-019 The running error flag SHALL be set if a_i > 9 or b_i > 9 for any processed digit; such digits SHALL still be processed per REQ-017.
REQ-020 On the edge that processes digit DIGITS-1, the FSM SHALL enter DONE and load sum, cout and err from the internal result.
REQ-021 sum, cout and err SHALL hold the previous result throughout RUN and change only per REQ-020 or on reset.
REQ-022 busy SHALL be 1 exactly while in RUN.
REQ-023 done SHALL be 1 exactly while in DONE.
REQ-024 DONE SHALL last one cycle, then return to IDLE unconditionally.
REQ-025 Latency: done SHALL rise DIGITS cycles after the accepting edge, and the next start SHALL be accepted no sooner than DIGITS+2 edges after the previous accepting edge.
REQ-026 start in RUN or DONE SHALL be ignored (not queued); changes to a, b or cin after acceptance SHALL have no effect on the operation in progress.
REQ-027 Carry out of the most significant digit SHALL drive cout; it SHALL NOT wrap into digit 0.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force the state to IDLE and set busy=0, done=0, sum=0, cout=0, err=0, and clear all internal registers.
REQ-029 rst asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow for it.
REQ-030 After rst deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification (DIGITS=4)
REQ-031 a=0x0034, b=0x0049, cin=0, start pulse -> busy for 4 cycles, then done=1 for one cycle with sum=0x0083, cout=0, err=0.
REQ-032 a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1, err=0; done exactly 4 cycles after the accepting edge.
REQ-033 a=0x0009, b=0x0008, cin=1 -> sum=0x0018, cout=0, err=0.
REQ-034 a=0x000A, b=0x0001, cin=0 -> err=1, sum=0x0011, cout=0.
REQ-035 start held high continuously with a changed during RUN -> only one operation accepted per IDLE visit, result uses the latched operands, next acceptance on the edge after DONE.
REQ-036 rst pulsed mid-RUN (after 2 digits) -> all outputs read 0 before the next clk edge, no done pulse follows, and a fresh start then completes correctly.

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: one shared single-digit add step per clock, LSB digit first.
// Operands are latched on acceptance; sum/cout/err update only when the last digit completes.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_r, b_r, res_r, res_nx;
  logic            carry_r, err_r;
  logic [CW-1:0]   cnt;

  logic [4:0]      s;
  logic [3:0]      dig;
  logic            cy, dig_err;

  // Operands shift right each step, so the digit being worked on always sits in [3:0]
  always_comb begin
    s       = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]} + {4'b0, carry_r};
    dig     = s[3:0];
    cy      = 1'b0;
    if (s > 5'd9) begin
      dig = s[3:0] + 4'd6;
      cy  = 1'b1;
    end
    dig_err = (a_r[3:0] > 4'd9) || (b_r[3:0] > 4'd9);
    res_nx  = (res_r >> 4) | (W'(dig) << (W - 4));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result digits enter at the top of res_r; after DIGITS steps digit 0 lands in [3:0]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      err_r   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r     <= a;
      b_r     <= b;
      carry_r <= cin;
      res_r   <= '0;
      err_r   <= 1'b0;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_r     <= a_r >> 4;
      b_r     <= b_r >> 4;
      carry_r <= cy;
      res_r   <= res_nx;
      err_r   <= err_r | dig_err;
      cnt     <= cnt + CW'(1);
      if (cnt == LAST) begin
        sum  <= res_nx;
        cout <= cy;
        err  <= err_r | dig_err;
      end
    end
  end

endmodule
